ones_pattern_gen: RTL and testbench

//  Inverse of the population-count path: takes a requested ones count and

---
 rtl/ones_pattern_gen_if.sv | 24 ++
 rtl/ones_pattern_gen.sv | 81 ++++++++
 tb/tb_ones_pattern_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ones_pattern_gen_if.sv
// Handshake and result bundle for the ones pattern generator.
// master drives the request side; slave is the generator itself.
interface ones_pattern_gen_if #(
  parameter int data_width  = 4,
  parameter int count_width = 3
);
  logic                   start;
  logic [count_width-1:0] bit_count;
  logic                   msb_first;
  logic [data_width-1:0]  data;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  modport master (
    output start, bit_count, msb_first,
    input  data, busy, done, overflow
  );

  modport slave (
    input  start, bit_count, msb_first,
    output data, busy, done, overflow
  );
endinterface

// File: rtl/ones_pattern_gen.sv
// Builds a word of k contiguous ones, one bit per clock, anchored at the LSB or MSB.
// state | meaning
// IDLE  | waiting for start; data/overflow hold the last result
// SHIFT | shifting in ones until the remaining count reaches zero
module ones_pattern_gen #(
  parameter int data_width  = 4,
  parameter int count_width = 3
) (
  input logic               clk,
  input logic               reset,
  ones_pattern_gen_if.slave bus
);

  localparam logic [count_width-1:0] WIDTH_C = count_width'(data_width);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state;
  logic [data_width-1:0]  temp;
  logic [count_width-1:0] rem;
  logic                   ovf;
  logic                   msb_mode;
  logic [data_width-1:0]  data_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   overflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      temp       <= '0;
      rem        <= '0;
      ovf        <= 1'b0;
      msb_mode   <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            temp     <= '0;
            // Oversized requests saturate to a full word and flag overflow.
            rem      <= (bus.bit_count > WIDTH_C) ? WIDTH_C : bus.bit_count;
            ovf      <= (bus.bit_count > WIDTH_C);
            msb_mode <= bus.msb_first;
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (rem != '0) begin
            if (msb_mode)
              temp <= {1'b1, temp[data_width-1:1]};
            else
              temp <= {temp[data_width-2:0], 1'b1};
            rem <= rem - count_width'(1);
          end else begin
            data_q     <= temp;
            overflow_q <= ovf;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data     = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed plus randomized checks of ones_pattern_gen against an arithmetic model.
module tb_ones_pattern_gen;

  localparam int W  = 4;
  localparam int CW = 3;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  ones_pattern_gen_if #(.data_width(W), .count_width(CW)) bus ();

  ones_pattern_gen #(.data_width(W), .count_width(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_k(input int bc);
    return (bc > W) ? W : bc;
  endfunction

  function automatic logic [31:0] model_data(input int bc, input bit msb);
    int k;
    int ones;
    k    = model_k(bc);
    ones = (1 << k) - 1;
    if (msb) ones = ones << (W - k);
    return 32'(ones);
  endfunction

  // One request; optionally pulses a stray start while busy.
  task automatic run_op(input int bc, input bit msb, input bit interfere);
    logic [31:0] exp_d;
    logic        exp_o;
    logic [W-1:0] prev_d;
    logic        prev_o;
    logic [31:0] cyc;
    bit          seen;
    logic [2:0]  bc3;
    exp_d = model_data(bc, msb);
    exp_o = (bc > W);
    bc3   = 3'(bc);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.bit_count = bc3;
    bus.msb_first = msb;
    prev_d = bus.data;
    prev_o = bus.overflow;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.bit_count = 3'($urandom_range(0, 7));
    bus.msb_first = 1'($urandom_range(0, 1));
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_low_after_start", 32'(bus.done), 32'd0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      if (interfere && cyc == 1) begin
        bus.start     = 1'b1;
        bus.bit_count = 3'd1;
        bus.msb_first = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      bus.start = 1'b0;
      if (bus.done) seen = 1;
      else begin
        check("busy_during_shift", 32'(bus.busy), 32'd1);
        check("data_stable", 32'(bus.data), 32'(prev_d));
        check("overflow_stable", 32'(bus.overflow), 32'(prev_o));
      end
    end
    check("done_timeout", 32'(seen), 32'd1);
    check("latency", cyc, 32'(model_k(bc) + 1));
    check("data", 32'(bus.data), exp_d);
    check("overflow", 32'(bus.overflow), 32'(exp_o));
    check("busy_low_at_done", 32'(bus.busy), 32'd0);
    check("popcount", 32'($countones(bus.data)), 32'(model_k(bc)));
    if (interfere) begin
      repeat (3) begin
        @(posedge clk);
        #1;
        check("no_queued_done", 32'(bus.done), 32'd0);
        check("no_queued_busy", 32'(bus.busy), 32'd0);
      end
      check("data_hold_after_ignore", 32'(bus.data), exp_d);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.start     = 1'b0;
    bus.bit_count = '0;
    bus.msb_first = 1'b0;
    #2;
    check("reset_data", 32'(bus.data), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(3, 1'b0, 1'b0);
    run_op(3, 1'b1, 1'b0);
    run_op(0, 1'b0, 1'b0);
    run_op(5, 1'b0, 1'b0);
    run_op(2, 1'b0, 1'b0);
    run_op(4, 1'b0, 1'b1);

    // Abort mid-operation with reset; data was nonzero beforehand.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.bit_count = 3'd4;
    bus.msb_first = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_data", 32'(bus.data), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_overflow", 32'(bus.overflow), 32'd0);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("post_reset_idle", 32'(bus.done), 32'd0);
    end
    run_op(2, 1'b0, 1'b0);

    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 8; c++)
        run_op(c, m[0], 1'b0);

    for (int i = 0; i < 30; i++)
      run_op(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
